conv2_window_gen: RTL and testbench

//  Sliding 3x3 window generator feeding conv2_dw. Takes a raster-order pixel stream (one pixel = CH channels x AW bits).

---
 rtl/conv2_window_gen.sv | 135 +++++++++++++
 tb/tb_conv2_window_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/conv2_window_gen.sv
// Sliding 3x3 window generator: two line buffers plus a per-channel 3x3 shift
// window turn a raster pixel stream into packed 9-tap windows for conv2_dw.
module conv2_window_gen #(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32,
  parameter int unsigned CH    = 8,
  parameter int unsigned AW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [CH*AW-1:0]      in_pix,
  output logic                  out_valid,
  output logic [9*CH*AW-1:0]    out_win,
  output logic                  frame_done,
  output logic                  sof_err
);

  localparam int unsigned PW = CH * AW;
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [PW-1:0] r_lb0 [IMG_W];
  logic [PW-1:0] r_lb1 [IMG_W];
  logic [PW-1:0] r_win [3][3];

  logic          w_take;
  logic          w_emit;
  logic          w_last_col;
  logic          w_last_row;
  logic [CW-1:0] w_wcol;
  logic [PW-1:0] w_top;
  logic [PW-1:0] w_mid;
  logic [PW-1:0] w_nxt [3][3];
  logic [9*PW-1:0] w_pack;

  // A beat is stored if it starts a frame or belongs to one in progress.
  assign w_take     = in_valid & (in_sof | (r_state != S_IDLE));
  assign w_emit     = in_valid & ~in_sof & (r_state == S_STREAM) & (r_col >= CW'(2));
  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_last_row = (r_row == RW'(IMG_H - 1));
  assign w_wcol     = in_sof ? '0 : r_col;
  assign w_top      = r_lb1[w_wcol];
  assign w_mid      = r_lb0[w_wcol];

  // Window after this beat's shift: oldest line on top, newest column on the right.
  always_comb begin
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 2; wc++) begin
        w_nxt[wr][wc] = r_win[wr][wc+1];
      end
    end
    w_nxt[0][2] = w_top;
    w_nxt[1][2] = w_mid;
    w_nxt[2][2] = in_pix;
  end

  always_comb begin
    w_pack = '0;
    for (int c = 0; c < CH; c++) begin
      for (int wr = 0; wr < 3; wr++) begin
        for (int wc = 0; wc < 3; wc++) begin
          w_pack[(c*9 + 3*wr + wc)*AW +: AW] = w_nxt[wr][wc][c*AW +: AW];
        end
      end
    end
  end

  // Line buffers are not reset; read-before-write falls out of non-blocking updates.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_lb1[w_wcol] <= r_lb0[w_wcol];
      r_lb0[w_wcol] <= in_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      out_valid  <= 1'b0;
      out_win    <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      for (int wr = 0; wr < 3; wr++) begin
        for (int wc = 0; wc < 3; wc++) begin
          r_win[wr][wc] <= '0;
        end
      end
    end else begin
      out_valid  <= w_emit;
      frame_done <= w_emit & w_last_col & w_last_row;
      if (w_emit) begin
        out_win <= w_pack;
      end
      if (w_take) begin
        for (int wr = 0; wr < 3; wr++) begin
          for (int wc = 0; wc < 3; wc++) begin
            r_win[wr][wc] <= w_nxt[wr][wc];
          end
        end
        if (in_sof) begin
          // The sof pixel is (0,0); counters move on to (0,1).
          if (r_state != S_IDLE) begin
            sof_err <= 1'b1;
          end
          r_state <= S_FILL;
          r_row   <= '0;
          r_col   <= CW'(1);
        end else if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_row <= r_row + RW'(1);
            if (r_row == RW'(1)) begin
              r_state <= S_STREAM;
            end
          end
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2_window_gen.sv
// Directed bench for conv2_window_gen on a 4x4, 2-channel image; windows are
// checked against a 3x3 extraction of the known pixel pattern.
module tb_conv2_window_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned CH = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned OW = 9 * CH * AW;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_sof;
  logic [CH*AW-1:0]   in_pix;
  logic               out_valid;
  logic [OW-1:0]      out_win;
  logic               frame_done;
  logic               sof_err;

  int n_cmp;
  int n_bad;
  int n_win;
  logic [OW-1:0] last_exp;

  conv2_window_gen #(.IMG_W(W), .IMG_H(H), .CH(CH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .out_valid(out_valid), .out_win(out_win), .frame_done(frame_done), .sof_err(sof_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ch0 = base + (4r+c); ch1 = (F0 + 4r+c) ^ base, which reaches FF at (3,3) for base 0.
  function automatic logic [CH*AW-1:0] pix(input int r, input int c, input logic [7:0] base);
    logic [7:0] p;
    p = 8'(4*r + c);
    return {8'(8'hF0 + p) ^ base, 8'(base + p)};
  endfunction

  function automatic logic [OW-1:0] exp_win(input int r, input int c, input logic [7:0] base);
    logic [OW-1:0]    w;
    logic [CH*AW-1:0] px;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      px = pix(r - 2 + k/3, c - 2 + k%3, base);
      for (int ch = 0; ch < CH; ch++) begin
        w[(ch*9 + k)*AW +: AW] = px[ch*AW +: AW];
      end
    end
    return w;
  endfunction

  task automatic beat(input logic sof, input int r, input int c, input logic [7:0] base,
                      input logic exp_v);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pix   = pix(r, c, base);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk("out_valid", OW'(out_valid), OW'(exp_v));
    chk("frame_done", OW'(frame_done), OW'(exp_v && r == H-1 && c == W-1));
    if (exp_v) begin
      last_exp = exp_win(r, c, base);
      chk("out_win", out_win, last_exp);
      if (base == 8'h00 && r == 2 && c == 2)
        chk("first_win_const", out_win, 144'hfaf9f8f6f5f4f2f1f0_0a0908060504020100);
    end
    if (out_valid) n_win++;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("gap_valid", OW'(out_valid), '0);
    chk("gap_hold", out_win, last_exp);
  endtask

  task automatic send_frame(input logic [7:0] base, input bit gaps, input int nbeats);
    int n;
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < nbeats) begin
          beat(r == 0 && c == 0, r, c, base, r >= 2 && c >= 2);
          if (gaps && (n % 2 == 0)) idle_cycle();
        end
        n++;
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    n_win    = 0;
    last_exp = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pix   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", OW'(out_valid), '0);
    chk("rst_win", out_win, '0);
    chk("rst_done", OW'(frame_done), '0);
    chk("rst_sof_err", OW'(sof_err), '0);

    // Beats without sof in idle are dropped.
    beat(1'b0, 3, 3, 8'h77, 1'b0);
    beat(1'b0, 2, 2, 8'h77, 1'b0);

    // Gapless frame, then a back-to-back frame with gaps and different data.
    n_win = 0;
    send_frame(8'h00, 1'b0, W*H);
    chk("f1_count", OW'(n_win), OW'(4));
    chk("last_win_const", out_win, 144'hfffefdfbfaf9f7f6f5_0f0e0d0b0a09070605);
    n_win = 0;
    send_frame(8'h20, 1'b1, W*H);
    chk("f2_count", OW'(n_win), OW'(4));
    chk("b2b_sof_err", OW'(sof_err), '0);
    idle_cycle();

    // Frame interrupted by sof in row 2; the restarted frame must be clean.
    send_frame(8'h30, 1'b0, 11);
    n_win = 0;
    send_frame(8'h40, 1'b0, W*H);
    chk("restart_count", OW'(n_win), OW'(4));
    chk("sof_err_set", OW'(sof_err), OW'(1));
    idle_cycle();
    chk("sof_err_sticky", OW'(sof_err), OW'(1));

    // Async reset right after a window pulse.
    send_frame(8'h50, 1'b0, 11);
    chk("pre_rst_valid", OW'(out_valid), OW'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", OW'(out_valid), '0);
    chk("arst_win", out_win, '0);
    chk("arst_sof_err", OW'(sof_err), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_exp = '0;
    n_win = 0;
    for (int i = 0; i < 12; i++) beat(1'b0, 2 + i/4, i%4, 8'h60, 1'b0);
    chk("post_rst_nowin", OW'(n_win), '0);
    send_frame(8'h70, 1'b1, W*H);
    chk("post_rst_count", OW'(n_win), OW'(4));
    chk("post_rst_sof_err", OW'(sof_err), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
